mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS CPU, replacing the single-cycle decoder. It sequences one shared ALU/memory datapath through fetch, decode, execute, memory and write-back states. It decodes the same instruction subset: add, sub, and, or, slt, sltu, addu, subu, nor, sll, jr, jalr, addi, ori, andi, lui, slti, lw, sw, beq, j, jal. Drives all datapath enables and muxes, and stalls on a unified memory ready handshake.

Parameters:
MEMRDY_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constantly 1.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous reset, active low
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC register load enable
IRWrite  out  1  IR load enable
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write enable
EXTOp  out  1  1 = sign-extend imm16
ALUSrcA  out  1  0 = PC, 1 = rs data
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
ALUOp  out  4  NOP0 ADD1 SUB2 AND3 OR4 SLT5 SLTU6 NOR7 SLL8 LUI9
NPCOp  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump, 11 = rs (jump register)
GPRSel  out  2  00 = rd, 01 = rt, 10 = $31
WDSel  out  2  00 = ALUOut, 01 = MDR, 10 = PC
state  out  4  current state, for debug
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported Op/Funct

Behaviour:
- State register is 4 bits. On clk edge with rstn=0, state <= FETCH (0). While rstn=0, all write/request outputs are forced 0 combinationally: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal_op.
- All outputs are decoded from state plus Op/Funct/Zero (Moore, with Zero qualifying in BRANCH). Unlisted outputs are 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9. Codes 10-15 go to FETCH next cycle with no side effects.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, NPCOp=00. If mem_ready=1: PCWrite=1, IRWrite=1, next = DECODE. Otherwise hold in FETCH with PCWrite=IRWrite=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, EXTOp=1, ALUOp=ADD (precompute branch target into ALUOut). Next state:
  - lw/sw -> MEMADR
  - R-type ALU ops, addi/ori/andi/lui/slti -> EXEC
  - beq -> BRANCH
  - j/jal/jr/jalr -> JUMP
  - anything else -> FETCH, with illegal_op=1 and instr_done=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. Next = MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1, MemRead=1. Advance to MEMWB on mem_ready, else hold.
- MEMWB: RegWrite=1, GPRSel=01, WDSel=01, instr_done=1. Next = FETCH.
- MEMWR: IorD=1, MemWrite=1 held until mem_ready. On mem_ready: instr_done=1, next = FETCH.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp per Funct.
  - I-type: ALUSrcB=10. ALUOp: addi ADD, ori OR, andi AND, slti SLT, lui LUI.
  - EXTOp=1 for addi/slti/lui only; ori/andi zero-extend.
  - Next = ALUWB.
- ALUWB: RegWrite=1, WDSel=00, GPRSel = 00 for R-type, 01 for I-type. instr_done=1. Next = FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, NPCOp=01, PCWrite=Zero, instr_done=1. Next = FETCH.
- JUMP:
  - PCWrite=1. NPCOp=10 for j/jal, 11 for jr/jalr.
  - jal: RegWrite=1, GPRSel=10, WDSel=10.
  - jalr: RegWrite=1, GPRSel=00, WDSel=10.
  - instr_done=1. Next = FETCH.
- Latency with mem_ready tied 1: R/I-ALU 4 cycles, lw 5, sw 4, beq/j/jal/jr/jalr 3. Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- sll is R-type Funct 000000. Op=0 with Funct=0x00 is sll, not illegal.
- Reset asserted mid-instruction (e.g. in MEMWR): write outputs drop in the same cycle, FETCH is entered on the next edge, and no partial register write occurs.

Test Plan:
- Reset: rstn=0 for 2 cycles from state 7 -> state=0, RegWrite=0 during reset; first FETCH with mem_ready=1 gives PCWrite=1, IRWrite=1.
- add (Op=0, Funct=0x20), mem_ready=1 -> states 0,1,6,7,0; EXEC ALUOp=1; ALUWB RegWrite=1, GPRSel=00; instr_done only in state 7.
- lw (Op=0x23) with mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; MEMWB WDSel=01, GPRSel=01; total 7 cycles.
- beq (Op=0x04): Zero=1 -> BRANCH PCWrite=1, NPCOp=01. Zero=0 -> PCWrite=0. Both 3 cycles.
- jal (Op=0x03) -> JUMP PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10. jr (Funct=0x08) -> NPCOp=11, RegWrite=0.
- Illegal Op=0x3F -> DECODE asserts illegal_op=1 for 1 cycle, then FETCH; no RegWrite/MemWrite. sw with rstn dropped in MEMWR -> MemWrite=0 that cycle, state=0 next.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared MIPS datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       EXTOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp,
               ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, state,
               instr_done, illegal_op
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp,
               ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, state,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, stalling on the unified memory ready handshake.
module mc_ctrl #(
    parameter bit MEMRDY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    mc_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_ALUWB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP   = 4'd9
    } state_e;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                           ALU_AND = 4'd3, ALU_OR  = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLTU = 4'd6, ALU_NOR = 4'd7, ALU_SLL = 4'd8,
                           ALU_LUI = 4'd9;

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic       is_r, is_lw, is_sw, is_beq, is_j, is_jal, is_i;
    logic       r_alu, r_jr, r_jalr, exec_cls, jump_cls;
    logic [3:0] r_aluop, i_aluop;
    logic       i_ext;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic       ext_op, alu_src_a, done, illegal;
    logic [1:0] alu_src_b, npc_op, gpr_sel, wd_sel;
    logic [3:0] alu_op;

    assign mem_rdy = MEMRDY_EN ? bus.mem_ready : 1'b1;
    assign is_r    = (bus.Op == 6'h00);
    assign is_lw   = (bus.Op == 6'h23);
    assign is_sw   = (bus.Op == 6'h2B);
    assign is_beq  = (bus.Op == 6'h04);
    assign is_j    = (bus.Op == 6'h02);
    assign is_jal  = (bus.Op == 6'h03);

    always_comb begin
        r_aluop = ALU_NOP;
        r_alu   = 1'b0;
        r_jr    = 1'b0;
        r_jalr  = 1'b0;
        case (bus.Funct)
            6'h20, 6'h21: begin r_aluop = ALU_ADD;  r_alu = 1'b1; end
            6'h22, 6'h23: begin r_aluop = ALU_SUB;  r_alu = 1'b1; end
            6'h24:        begin r_aluop = ALU_AND;  r_alu = 1'b1; end
            6'h25:        begin r_aluop = ALU_OR;   r_alu = 1'b1; end
            6'h27:        begin r_aluop = ALU_NOR;  r_alu = 1'b1; end
            6'h2A:        begin r_aluop = ALU_SLT;  r_alu = 1'b1; end
            6'h2B:        begin r_aluop = ALU_SLTU; r_alu = 1'b1; end
            6'h00:        begin r_aluop = ALU_SLL;  r_alu = 1'b1; end
            6'h08:        r_jr   = 1'b1;
            6'h09:        r_jalr = 1'b1;
            default:      ;
        endcase
    end

    // ori/andi zero-extend their immediate; the rest sign-extend
    always_comb begin
        is_i    = 1'b1;
        i_aluop = ALU_NOP;
        i_ext   = 1'b0;
        case (bus.Op)
            6'h08:   begin i_aluop = ALU_ADD; i_ext = 1'b1; end
            6'h0A:   begin i_aluop = ALU_SLT; i_ext = 1'b1; end
            6'h0F:   begin i_aluop = ALU_LUI; i_ext = 1'b1; end
            6'h0D:   i_aluop = ALU_OR;
            6'h0C:   i_aluop = ALU_AND;
            default: is_i = 1'b0;
        endcase
    end

    assign exec_cls = (is_r && r_alu) || is_i;
    assign jump_cls = is_j || is_jal || (is_r && (r_jr || r_jalr));

    always_comb begin
        state_d   = S_FETCH;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        ext_op    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = ALU_NOP;
        npc_op    = 2'b00;
        gpr_sel   = 2'b00;
        wd_sel    = 2'b00;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                pc_write  = mem_rdy;
                ir_write  = mem_rdy;
                state_d   = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                if (is_lw || is_sw)  state_d = S_MEMADR;
                else if (exec_cls)   state_d = S_EXEC;
                else if (is_beq)     state_d = S_BRANCH;
                else if (jump_cls)   state_d = S_JUMP;
                else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                state_d   = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                gpr_sel   = 2'b01;
                wd_sel    = 2'b01;
                done      = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                done      = mem_rdy;
                state_d   = mem_rdy ? S_FETCH : S_MEMWR;
            end
            // I-type ops also take rs on port A
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                if (is_r) begin
                    alu_op = r_aluop;
                end else begin
                    alu_src_b = 2'b10;
                    alu_op    = i_aluop;
                    ext_op    = i_ext;
                end
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                gpr_sel   = is_r ? 2'b00 : 2'b01;
                done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                npc_op    = 2'b01;
                pc_write  = bus.Zero;
                done      = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                done     = 1'b1;
                if (is_r) begin
                    npc_op = 2'b11;
                    if (r_jalr) begin
                        reg_write = 1'b1;
                        wd_sel    = 2'b10;
                    end
                end else begin
                    npc_op = 2'b10;
                    if (is_jal) begin
                        reg_write = 1'b1;
                        gpr_sel   = 2'b10;
                        wd_sel    = 2'b10;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Side-effecting strobes are gated by reset so a mid-instruction reset writes nothing
    assign bus.PCWrite    = pc_write  & rstn;
    assign bus.IRWrite    = ir_write  & rstn;
    assign bus.MemRead    = mem_read  & rstn;
    assign bus.MemWrite   = mem_write & rstn;
    assign bus.RegWrite   = reg_write & rstn;
    assign bus.instr_done = done      & rstn;
    assign bus.illegal_op = illegal   & rstn;
    assign bus.IorD       = iord;
    assign bus.EXTOp      = ext_op;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUOp      = alu_op;
    assign bus.NPCOp      = npc_op;
    assign bus.GPRSel     = gpr_sel;
    assign bus.WDSel      = wd_sel;
    assign bus.state      = state_q;
endmodule
